ysyx_23060203_axi_sram: RTL and testbench
=========================================

// Module: ysyx_23060203_axi_sram
// PURPOSE
//  AXI4 responder backing a word-addressed SRAM model; the memory-side target of the LSU and IFU AXI initiators.
//  Read and write channels run independent FSMs with programmable response latency; reads support INCR/FIXED
//  bursts, writes are single-beat with byte strobes. Out-of-range addresses return SLVERR.
// PARAMETERS
//  DEPTH   1024  memory size in 32-bit words (power of 2); valid byte addresses 0 .. DEPTH*4-1
//  R_LAT   2     cycles from AR handshake to first rvalid (0..15; 0 => rvalid the cycle after AR handshake)
//  W_LAT   2     cycles from AW+W both captured to bvalid (0..15; 0 => bvalid the cycle after)
//  ID_W    4     AXI ID width
// PORTS
//  clock    in  1     clock
//  reset    in  1     asynchronous, active-high reset
//  arvalid  in  1     read addr valid;   arready out 1  read addr ready
//  araddr   in  32    read byte address; arid in ID_W; arlen in 8 (beats-1); arsize in 3; arburst in 2 (0 FIXED, 1 INCR)
//  rvalid   out 1     read data valid;   rready in 1
//  rdata    out 32    full aligned word; rresp out 2 (00 OKAY, 10 SLVERR); rid out ID_W; rlast out 1
//  awvalid  in  1     write addr valid;  awready out 1; awaddr in 32; awid in ID_W; awlen in 8; awsize in 3; awburst in 2
//  wvalid   in  1     write data valid;  wready out 1; wdata in 32; wstrb in 4; wlast in 1
//  bvalid   out 1     write resp valid;  bready in 1; bresp out 2; bid out ID_W
// BEHAVIOUR
//  Reset: async; while reset=1 all ready/valid outputs 0, rdata/rresp/bresp/rid/bid/rlast 0, FSMs -> IDLE,
//   counters 0. Memory contents are NOT reset. Reset mid-transaction abandons it; no partial write beyond what already committed.
//  Read FSM R_IDLE -> R_WAIT -> R_DATA:
//   R_IDLE: arready=1. On arvalid: latch araddr, arid, arlen, arburst, beat cnt=0, lat cnt=R_LAT; -> R_WAIT.
//   R_WAIT: arready=0; decrement lat cnt; when 0 (or immediately if R_LAT=0), sample mem[addr[.:2]] into rdata -> R_DATA.
//   R_DATA: rvalid=1; rdata/rresp/rid/rlast stable until rready. rlast = (beat cnt == len).
//    On rready & !rlast: beat++, addr += 4 if INCR (FIXED: unchanged), fetch next word, stay R_DATA with rvalid=1 next cycle
//    (subsequent beats zero extra latency). On rready & rlast: -> R_IDLE (no back-to-back arready in same cycle).
//   rdata is the whole aligned word; lane extraction by addr[1:0] is the initiator's job. arsize is ignored.
//   Address >= DEPTH*4 (per beat): rresp=10, rdata=0; no memory access.
//  Write FSM W_IDLE, W_ADDR (have AW), W_DATA (have W), W_WAIT, W_RESP:
//   W_IDLE: awready=1, wready=1. AW&W same cycle -> W_WAIT; AW only -> W_ADDR; W only -> W_DATA.
//   W_ADDR: awready=0, wready=1; on wvalid -> W_WAIT. W_DATA: awready=1, wready=0; on awvalid -> W_WAIT.
//   Entering W_WAIT: lat cnt=W_LAT. When lat cnt reaches 0 commit: for each i with wstrb[i]=1,
//    mem[awaddr[.:2]].byte[i] <= wdata[8i+7:8i]; -> W_RESP the same edge.
//   W_RESP: bvalid=1, bid=latched awid, bresp stable until bready; on bready -> W_IDLE.
//   awlen!=0 or wlast=0: bresp=10, no commit. Out-of-range awaddr: bresp=10, no commit.
//  Read/write ordering: channels independent. If commit and read sample hit the same word on the same edge,
//   read returns OLD data; any read sampled after the commit edge returns NEW data.
//  Outputs are driven from registers/state only; no combinational path from any input to any output.
// TESTING
//  1. R_LAT=2: AR addr 0x10 (mem[4]=0xDEADBEEF), rready=1 -> rvalid exactly 3 cycles after AR handshake, rdata 0xDEADBEEF, rresp 00, rlast 1.
//  2. AW 0x22 then W 2 cycles later, wdata 0x00AB0000 wstrb 0100 on word 0x11223344 -> bvalid after W_LAT+1, word reads 0x11AB3344.
//  3. W before AW, and AW+W same cycle, arid/awid=5 -> both accepted once, bid=5, single bvalid pulse per write.
//  4. INCR burst arlen=3 at 0x0 with rready toggling 1,0,1,... -> 4 beats 0x0..0xC in order, data held while rready=0, rlast only on beat 4.
//  5. araddr=DEPTH*4, awaddr=DEPTH*4 -> rresp=10 rdata=0; bresp=10 and no memory word changed.
//  6. Assert reset during R_WAIT and W_RESP -> all valids/readies 0 immediately (asynchronously); after release arready=awready=wready=1, memory intact.

Source files
------------

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4 responder in front of a word-addressed SRAM model.
// Read and write channels run independent state machines, each with a fixed
// programmable response latency. Reads support FIXED/INCR bursts; writes are
// single-beat with byte strobes. Addresses beyond the array answer SLVERR.
module ysyx_23060203_axi_sram #(
  parameter int DEPTH = 1024,
  parameter int R_LAT = 2,
  parameter int W_LAT = 2,
  parameter int ID_W  = 4
) (
  input  logic            clock,
  input  logic            reset,
  // read address channel
  input  logic            arvalid,
  output logic            arready,
  input  logic [31:0]     araddr,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  // read data channel
  output logic            rvalid,
  input  logic            rready,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic [ID_W-1:0] rid,
  output logic            rlast,
  // write address channel
  input  logic            awvalid,
  output logic            awready,
  input  logic [31:0]     awaddr,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  // write data channel
  input  logic            wvalid,
  output logic            wready,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  // write response channel
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  output logic [ID_W-1:0] bid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_WAIT, W_RESP} w_state_t;

  // Byte address falls inside the array when no bit above the word index is set.
  function automatic logic in_range(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  logic [31:0] mem [DEPTH];

  r_state_t        r_state;
  logic [31:0]     r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic            r_fixed;
  logic [3:0]      r_lat;
  logic [31:0]     r_next_addr;
  logic [31:0]     r_fetch_addr;
  logic [31:0]     r_fetch_data;
  logic [1:0]      r_fetch_resp;

  w_state_t        w_state;
  logic [31:0]     w_addr;
  logic [ID_W-1:0] w_id;
  logic [7:0]      w_len;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;
  logic [3:0]      w_lat;
  logic            w_ok;
  logic            commit;

  // Size and write-burst type carry no meaning for a word-wide single-beat target.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, awsize, awburst};

  // Select the word the read channel fetches this cycle: first beat from the
  // latched address, following beats from the advanced address.
  always_comb begin
    r_next_addr  = r_fixed ? r_addr : r_addr + 32'd4;
    r_fetch_addr = (r_state == R_DATA) ? r_next_addr : r_addr;
    r_fetch_data = 32'd0;
    r_fetch_resp = RESP_SLVERR;
    if (in_range(r_fetch_addr)) begin
      r_fetch_data = mem[word_idx(r_fetch_addr)];
      r_fetch_resp = RESP_OKAY;
    end
  end

  // Read channel: accept AR, count down the latency, then stream the beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= 2'b00;
      rid     <= '0;
      rlast   <= 1'b0;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_beat  <= 8'd0;
      r_fixed <= 1'b0;
      r_lat   <= 4'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr;
            rid     <= arid;
            r_len   <= arlen;
            r_fixed <= (arburst == 2'b00);
            r_beat  <= 8'd0;
            r_lat   <= 4'(R_LAT);
            arready <= 1'b0;
            r_state <= R_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            rdata   <= r_fetch_data;
            rresp   <= r_fetch_resp;
            rlast   <= (r_len == 8'd0);
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (!rlast) begin
              r_addr <= r_next_addr;
              r_beat <= r_beat + 8'd1;
              rdata  <= r_fetch_data;
              rresp  <= r_fetch_resp;
              rlast  <= ((r_beat + 8'd1) == r_len);
            end else begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // A write commits only for a single-beat, properly terminated, in-range access.
  assign w_ok   = (w_len == 8'd0) && w_last && in_range(w_addr);
  assign commit = (w_state == W_WAIT) && (w_lat == 4'd0) && w_ok;

  // Byte-lane update of the array; contents survive reset.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[word_idx(w_addr)][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // Write channel: collect AW and W in either order, wait, commit, respond.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      bid     <= '0;
      w_addr  <= 32'd0;
      w_id    <= '0;
      w_len   <= 8'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      w_last  <= 1'b0;
      w_lat   <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready && wvalid && wready) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            w_data  <= wdata;
            w_strb  <= wstrb;
            w_last  <= wlast;
            w_lat   <= 4'(W_LAT);
            awready <= 1'b0;
            wready  <= 1'b0;
            w_state <= W_WAIT;
          end else if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_ADDR;
          end else if (wvalid && wready) begin
            w_data  <= wdata;
            w_strb  <= wstrb;
            w_last  <= wlast;
            awready <= 1'b1;
            wready  <= 1'b0;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        W_ADDR: begin
          if (wvalid && wready) begin
            w_data  <= wdata;
            w_strb  <= wstrb;
            w_last  <= wlast;
            w_lat   <= 4'(W_LAT);
            wready  <= 1'b0;
            w_state <= W_WAIT;
          end
        end
        W_DATA: begin
          if (awvalid && awready) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            w_lat   <= 4'(W_LAT);
            awready <= 1'b0;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_lat == 4'd0) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
            bid     <= w_id;
            w_state <= W_RESP;
          end else begin
            w_lat <= w_lat - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_axi_sram.sv
// Randomized bench for the AXI SRAM responder against a word-array reference.
module tb_ysyx_23060203_axi_sram;

  localparam int DEPTH = 1024;
  localparam int R_LAT = 2;
  localparam int W_LAT = 2;
  localparam int ID_W  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            arvalid, arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid, rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [ID_W-1:0] rid;
  logic            rlast;
  logic            awvalid, awready;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            wvalid, wready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  logic [31:0] ref_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  ysyx_23060203_axi_sram #(.DEPTH(DEPTH), .R_LAT(R_LAT), .W_LAT(W_LAT), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len;
    awsize = 3'd2; awburst = 2'd1;
  endtask

  task automatic set_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
  endtask

  // mode 0: AW and W together; 1: AW then W after gap; 2: W then AW after gap.
  task automatic axi_write(input logic [31:0] addr, input logic [ID_W-1:0] id,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [7:0] len, input logic last,
                           input int mode, input int gap, input bit hold);
    int cnt;
    logic [1:0] exp_resp;
    cnt = 0;
    while (!(awready && wready) && cnt < 20) begin tick(); cnt++; end
    chk("w_idle_ready", 32'({awready, wready}), 32'd3);
    if (mode == 0) begin
      set_aw(addr, id, len); set_w(data, strb, last);
      tick(); awvalid = 1'b0; wvalid = 1'b0;
    end else if (mode == 1) begin
      set_aw(addr, id, len);
      tick(); awvalid = 1'b0;
      chk("awready_busy", 32'(awready), 32'd0);
      repeat (gap) begin chk("bvalid_early", 32'(bvalid), 32'd0); tick(); end
      set_w(data, strb, last);
      tick(); wvalid = 1'b0;
    end else begin
      set_w(data, strb, last);
      tick(); wvalid = 1'b0;
      chk("wready_busy", 32'(wready), 32'd0);
      repeat (gap) begin chk("bvalid_early", 32'(bvalid), 32'd0); tick(); end
      set_aw(addr, id, len);
      tick(); awvalid = 1'b0;
    end
    cnt = 0;
    while (!bvalid && cnt < 40) begin tick(); cnt++; end
    chk("b_latency", 32'(cnt), 32'(W_LAT + 1));
    exp_resp = (len == 8'd0 && last && addr < 32'(DEPTH * 4)) ? 2'b00 : 2'b10;
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("bid", 32'(bid), 32'(id));
    if (exp_resp == 2'b00) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) ref_mem[addr[31:2]][8*i +: 8] = data[8*i +: 8];
    end
    if (!hold) begin
      repeat ($urandom_range(0, 2)) begin tick(); chk("bvalid_hold", 32'(bvalid), 32'd1); end
      bready = 1'b1;
      tick(); bready = 1'b0;
      chk("bvalid_pulse", 32'(bvalid), 32'd0);
    end
  endtask

  // rmode 0: rready always 1; 1: toggling 1,0,1,...; 2: random.
  task automatic axi_read(input logic [31:0] addr, input logic [ID_W-1:0] id,
                          input logic [7:0] len, input logic [1:0] burst, input int rmode);
    int cnt, beat, cyc;
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    logic rr;
    cnt = 0;
    while (!arready && cnt < 20) begin tick(); cnt++; end
    chk("arready_idle", 32'(arready), 32'd1);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'd2; arburst = burst;
    tick(); arvalid = 1'b0;
    chk("arready_busy", 32'(arready), 32'd0);
    cnt = 0;
    while (!rvalid && cnt < 40) begin tick(); cnt++; end
    chk("r_latency", 32'(cnt), 32'(R_LAT + 1));
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      a = (burst == 2'd0) ? addr : addr + 32'(4 * beat);
      if (a < 32'(DEPTH * 4)) begin exp_d = ref_mem[a[31:2]]; exp_r = 2'b00; end
      else begin exp_d = 32'd0; exp_r = 2'b10; end
      if (rmode == 0) rr = 1'b1;
      else if (rmode == 1) rr = (cyc % 2 == 0);
      else rr = 1'($urandom_range(0, 1));
      rready = rr;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, exp_d);
      chk("rresp", 32'(rresp), 32'(exp_r));
      chk("rid", 32'(rid), 32'(id));
      chk("rlast", 32'(rlast), 32'(beat == int'(len)));
      tick(); cyc++;
      if (rr) beat++;
    end
    rready = 1'b0;
    chk("r_beats", 32'(beat), 32'(int'(len) + 1));
    chk("rvalid_done", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic chk_all_low(input string tag);
    chk(tag, 32'({arready, rvalid, awready, wready, bvalid, rlast}), 32'd0);
    chk({tag, "_data"}, rdata, 32'd0);
    chk({tag, "_resp"}, 32'({rresp, bresp}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (3) tick();
    chk_all_low("reset_state");
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'({arready, awready, wready}), 32'd7);

    // Initialise the low 64 words and the top two words.
    for (int w = 0; w < 64; w++)
      axi_write(32'(w * 4), 4'($urandom_range(0, 15)), $urandom, 4'hF, 8'd0, 1'b1,
                $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    axi_write(32'((DEPTH - 2) * 4), 4'd1, $urandom, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);
    axi_write(32'((DEPTH - 1) * 4), 4'd2, $urandom, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);

    // Single read with known word.
    axi_write(32'h10, 4'd3, 32'hDEADBEEF, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);
    axi_read(32'h10, 4'd3, 8'd0, 2'd1, 0);

    // Partial strobe write with AW leading W by two cycles.
    axi_write(32'h20, 4'd4, 32'h11223344, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);
    axi_write(32'h22, 4'd1, 32'h00AB0000, 4'b0100, 8'd0, 1'b1, 1, 2, 1'b0);
    axi_read(32'h20, 4'd1, 8'd0, 2'd1, 0);

    // W before AW, and AW+W together, both with id 5.
    axi_write(32'h30, 4'd5, $urandom, 4'hF, 8'd0, 1'b1, 2, 2, 1'b0);
    axi_write(32'h34, 4'd5, $urandom, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);
    axi_read(32'h30, 4'd5, 8'd1, 2'd1, 0);

    // Bursts with backpressure.
    axi_read(32'h0, 4'd2, 8'd3, 2'd1, 1);
    axi_read(32'h8, 4'd7, 8'd2, 2'd0, 1);

    // Out-of-range and malformed accesses.
    axi_read(32'(DEPTH * 4), 4'd6, 8'd0, 2'd1, 0);
    axi_write(32'(DEPTH * 4), 4'd6, 32'hFFFF_FFFF, 4'hF, 8'd0, 1'b1, 0, 0, 1'b0);
    axi_write(32'h4, 4'd6, 32'hCAFE_F00D, 4'hF, 8'd1, 1'b1, 0, 0, 1'b0);
    axi_write(32'h8, 4'd6, 32'hCAFE_F00D, 4'hF, 8'd0, 1'b0, 1, 1, 1'b0);
    axi_read(32'h0, 4'd6, 8'd2, 2'd1, 0);
    axi_read(32'((DEPTH - 2) * 4), 4'd9, 8'd3, 2'd1, 2);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(32'($urandom_range(0, 63) * 4), 4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0,
                  ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
                  $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      else
        axi_read(32'($urandom_range(0, 56) * 4), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 7)), 2'($urandom_range(0, 1)), 2);
    end

    // Reset while the read channel waits on latency.
    while (!arready) tick();
    arvalid = 1'b1; araddr = 32'h10; arid = 4'd3; arlen = 8'd0; arburst = 2'd1;
    tick(); arvalid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all_low("reset_in_rwait");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("ready_after_rwait_reset", 32'({arready, awready, wready, rvalid}), 32'd14);

    // Reset while a write response is pending.
    axi_write(32'h40, 4'd6, $urandom, 4'hF, 8'd0, 1'b1, 0, 0, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all_low("reset_in_wresp");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("ready_after_wresp_reset", 32'({arready, awready, wready, bvalid}), 32'd14);
    axi_read(32'h38, 4'd8, 8'd3, 2'd1, 0);
    axi_read(32'h10, 4'd8, 8'd0, 2'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
